rr_stream_arbiter: RTL
======================

// Module: rr_stream_arbiter
// PURPOSE
//   N-to-1 round-robin arbiter that merges N valid/ready streams onto one shared
//   downstream channel, typically the single input port of a shared fifo.
//   Holds one registered output slot, so requesters see one cycle of latency.
//   Each output beat carries its source index, so consumers can demux it.
// PARAMETERS
//   N      4   number of requesters, >= 1; need not be a power of 2
//   W      8   payload width in bits
//   SRC_W  derived localparam = max(1, $clog2(N)); width of out_src
// PORTS
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       synchronous reset, active low
//   in_valid     in   N       per-requester valid
//   in_payload   in   N*W     requester i occupies bits [i*W +: W]
//   in_ready     out  N       one-hot or zero; accept for the granted requester
//   out_valid    out  1       output slot holds a beat
//   out_payload  out  W       registered payload
//   out_src      out  SRC_W   index of the requester that produced the beat
//   out_ready    in   1       downstream accept
//   in_last      in   N       only with RR_ARB_LAST_LOCK_EN; end-of-packet flag
//   out_last     out  1       only with RR_ARB_LAST_LOCK_EN; registered copy of in_last
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out_valid=0, out_payload=0, out_src=0,
//     out_last=0, rr_ptr=0, lock state cleared. rst_n=0 overrides all other activity.
//     Any beat already in the slot is dropped; no in_ready is honoured in that cycle.
//   - load_en = ~out_valid | out_ready. The slot may drain and refill in the same
//     cycle, giving one beat per cycle sustained.
//   - Grant g: the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ...,
//     N-1, 0, ... rr_ptr-1. The scan wraps at N, not at 2^SRC_W.
//   - in_ready[g] = load_en & any(in_valid). All other in_ready bits are 0.
//     in_ready is combinational from in_valid, out_valid, out_ready and state.
//   - On transfer (load_en & any valid), at the posedge:
//     out_payload <= in_payload[g]; out_src <= g; out_valid <= 1;
//     rr_ptr <= (g==N-1) ? 0 : g+1.
//   - If load_en is set, no requester is valid, and out_ready is set:
//     out_valid <= 0 and rr_ptr is unchanged.
//   - Stall (out_valid & ~out_ready): out_payload, out_src and out_last stay stable.
//     All in_ready bits are 0 and rr_ptr is unchanged.
//   - Latency: an input accepted at edge k is presented on out_* from edge k onward.
//   - Fairness: with all N requesters continuously valid and out_ready=1, grants
//     cycle 0,1,...,N-1,0,...; no requester waits more than N-1 transfers.
//   - N=1: the arbiter degenerates to a one-stage register slice; out_src is always 0.
// CONFIGURATION
//   RR_ARB_LAST_LOCK_EN defined:
//   - Adds in_last and out_last; out_last is registered alongside out_payload.
//   - Accepting a beat with in_last=0 sets locked=1 and lock_src=g.
//     While locked, only lock_src is eligible and rr_ptr does not advance.
//   - Accepting a beat with in_last=1 clears the lock and sets rr_ptr <= g+1 (wrapped).
//     A one-beat packet (in_last=1 on its first beat) never locks.
//   - While locked and in_valid[lock_src]=0, the output idles. No other
//     requester is granted, even if valid.
//   RR_ARB_LAST_LOCK_EN undefined:
//   - No in_last/out_last ports; every beat is arbitrated independently.
// TESTING
//   T1 reset: hold rst_n=0 3 cycles, all in_valid=1 -> out_valid=0, in_ready=0,
//      out_src=0; first grant after release goes to requester 0.
//   T2 fairness, N=4: all valid, out_ready=1, 8 cycles -> out_src 0,1,2,3,0,1,2,3,
//      with payload matching the source at each beat.
//   T3 stall: out_valid=1, out_src=2, payload 0xA5, out_ready=0 for 5 cycles ->
//      payload and src stable, in_ready=0; release -> next grant is 3 if valid.
//   T4 sparse/wrap, N=3 (non-power-of-2): only in_valid[0] and in_valid[2]
//      -> grants 0,2,0,2; rr_ptr never reaches 3.
//   T5 lock (macro on): req1 sends 3 beats with last on the 3rd, req0/2 held valid
//      -> out_src 1,1,1 then 2,0; a 1-cycle gap in req1 mid-packet idles the output.
//   T6 reset mid-stream: rst_n=0 while out_valid=1 and locked -> next cycle
//      out_valid=0, lock cleared, rr_ptr=0.

Source files
------------

// File: rtl/rr_stream_arbiter_if.sv
// rtl/rr_stream_arbiter_if.sv - N-wide request side and single output slot of the round-robin stream arbiter
// Optional packet-lock signals appear only when RR_ARB_LAST_LOCK_EN is defined.
interface rr_stream_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_payload;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_payload;
  logic [SRC_W-1:0] out_src;
  logic             out_ready;
`ifdef RR_ARB_LAST_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;

  modport slave (
    input  in_valid, in_payload, in_last, out_ready,
    output in_ready, out_valid, out_payload, out_src, out_last
  );
  modport master (
    output in_valid, in_payload, in_last, out_ready,
    input  in_ready, out_valid, out_payload, out_src, out_last
  );
`else
  modport slave (
    input  in_valid, in_payload, out_ready,
    output in_ready, out_valid, out_payload, out_src
  );
  modport master (
    output in_valid, in_payload, out_ready,
    input  in_ready, out_valid, out_payload, out_src
  );
`endif
endinterface

// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - N-to-1 round-robin stream arbiter with one registered output slot
// Define RR_ARB_LAST_LOCK_EN to hold the grant on one requester until its in_last beat.
module rr_stream_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_stream_arbiter_if.slave  bus
);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N - 1);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] next_ptr;
  logic [N-1:0]     eligible;
  logic             any_valid;
  logic             load_en;
  logic             take;
  logic [W-1:0]     grant_payload;

  logic             out_valid_q;
  logic [W-1:0]     out_payload_q;
  logic [SRC_W-1:0] out_src_q;

`ifdef RR_ARB_LAST_LOCK_EN
  logic             locked;
  logic [SRC_W-1:0] lock_src;
  logic             out_last_q;
  logic             grant_last;
`endif

  // While a packet is in flight only its owner may be granted.
  always_comb begin
    eligible = bus.in_valid;
`ifdef RR_ARB_LAST_LOCK_EN
    if (locked) begin
      eligible = bus.in_valid & (N'(1) << lock_src);
    end
`endif
  end

  // Scan wraps at N so non-power-of-2 counts never visit phantom requesters.
  always_comb begin : scan
    int idx;
    idx       = 0;
    grant_idx = rr_ptr;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_valid && eligible[idx]) begin
        any_valid = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    grant_payload = bus.in_payload[int'(grant_idx)*W +: W];
    next_ptr      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    load_en       = ~out_valid_q | bus.out_ready;
    take          = rst_n & load_en & any_valid;
    bus.in_ready  = take ? (N'(1) << grant_idx) : '0;
  end

`ifdef RR_ARB_LAST_LOCK_EN
  assign grant_last = bus.in_last[grant_idx];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_src_q     <= '0;
      rr_ptr        <= '0;
`ifdef RR_ARB_LAST_LOCK_EN
      out_last_q    <= 1'b0;
      locked        <= 1'b0;
      lock_src      <= '0;
`endif
    end else if (take) begin
      out_valid_q   <= 1'b1;
      out_payload_q <= grant_payload;
      out_src_q     <= grant_idx;
`ifdef RR_ARB_LAST_LOCK_EN
      out_last_q    <= grant_last;
      if (grant_last) begin
        locked <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        locked   <= 1'b1;
        lock_src <= grant_idx;
      end
`else
      rr_ptr        <= next_ptr;
`endif
    end else if (load_en) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_payload = out_payload_q;
  assign bus.out_src     = out_src_q;
`ifdef RR_ARB_LAST_LOCK_EN
  assign bus.out_last    = out_last_q;
`endif

endmodule
